apb_wdt: RTL and testbench

APB3/APB4 watchdog timer that sits on the peripheral APB bus behind the AXI-to-APB bridge. It responds to APB transfers and keeps a free-running 32-bit down-counter. It raises `o_irq_wdt` on the first timeout and asserts a sticky system reset request on a second timeout if the interrupt is still unserviced. A write-lock register protects the configuration.

---
 rtl/apb_wdt.sv | 143 ++++++++++++++
 tb/tb_apb_wdt.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wdt.sv
// APB watchdog timer: free-running 32-bit down-counter with a first-timeout interrupt,
// a sticky reset request on an unserviced second timeout, and a key-protected write lock.
module apb_wdt #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] LOAD_RST = 32'h0000_FFFF,
  parameter logic [31:0] LOCK_KEY = 32'h1ACC_E551
) (
  input  logic              i_pclk,
  input  logic              i_preset,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_pwrite,
  input  logic [31:0]       i_pwdata,
  input  logic [2:0]        i_pprot,
  input  logic [3:0]        i_pstrb,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_irq_wdt,
  output logic              o_wdt_reset
);

  localparam logic [ADDR_W-3:0] IDX_CTRL   = 'd0;
  localparam logic [ADDR_W-3:0] IDX_LOAD   = 'd1;
  localparam logic [ADDR_W-3:0] IDX_VALUE  = 'd2;
  localparam logic [ADDR_W-3:0] IDX_INTCLR = 'd3;
  localparam logic [ADDR_W-3:0] IDX_RIS    = 'd4;
  localparam logic [ADDR_W-3:0] IDX_MIS    = 'd5;
  localparam logic [ADDR_W-3:0] IDX_LOCK   = 'd6;

  logic              ctrl_inten;
  logic              ctrl_resen;
  logic [31:0]       load_q;
  logic [31:0]       value_q;
  logic              ris_q;
  logic              locked_q;
  logic              wdt_reset_q;

  logic [ADDR_W-3:0] widx;
  logic              access;
  logic              sel_ctrl, sel_load, sel_value, sel_intclr, sel_ris, sel_mis, sel_lock;
  logic              mapped;
  logic              err;
  logic              wr_ok;
  logic              full_strb;
  logic              do_ctrl, do_load, do_intclr, do_lock;
  logic [31:0]       load_next;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign widx        = i_paddr[ADDR_W-1:2];
  assign access      = i_psel & i_penable;
  assign unused_bits = ^{i_pprot[2:1], i_paddr[1:0]};

  assign sel_ctrl   = (widx == IDX_CTRL);
  assign sel_load   = (widx == IDX_LOAD);
  assign sel_value  = (widx == IDX_VALUE);
  assign sel_intclr = (widx == IDX_INTCLR);
  assign sel_ris    = (widx == IDX_RIS);
  assign sel_mis    = (widx == IDX_MIS);
  assign sel_lock   = (widx == IDX_LOCK);
  assign mapped     = sel_ctrl | sel_load | sel_value | sel_intclr | sel_ris | sel_mis | sel_lock;

  // LOCK stays writable while locked so software can always unlock.
  assign err = ~mapped |
               (i_pwrite & (~i_pprot[0] | sel_value | sel_ris | sel_mis |
                            (locked_q & (sel_ctrl | sel_load | sel_intclr))));

  assign wr_ok     = access & i_pwrite & ~err;
  assign full_strb = (i_pstrb == 4'hF);
  assign do_ctrl   = wr_ok & sel_ctrl & i_pstrb[0];
  assign do_load   = wr_ok & sel_load;
  assign do_intclr = wr_ok & sel_intclr & full_strb;
  assign do_lock   = wr_ok & sel_lock & full_strb;

  always_comb begin
    load_next = load_q;
    for (int b = 0; b < 4; b++) begin
      if (i_pstrb[b]) load_next[8*b +: 8] = i_pwdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (access && !i_pwrite) begin
      case (widx)
        IDX_CTRL:  rdata = {30'd0, ctrl_resen, ctrl_inten};
        IDX_LOAD:  rdata = load_q;
        IDX_VALUE: rdata = value_q;
        IDX_RIS:   rdata = {31'd0, ris_q};
        IDX_MIS:   rdata = {31'd0, ris_q & ctrl_inten};
        IDX_LOCK:  rdata = {31'd0, locked_q};
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign o_prdata    = rdata;
  assign o_pready    = 1'b1;
  assign o_pslverr   = access & err;
  assign o_irq_wdt   = ris_q & ctrl_inten;
  assign o_wdt_reset = wdt_reset_q;

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      ctrl_inten <= 1'b0;
      ctrl_resen <= 1'b0;
      load_q     <= LOAD_RST;
      locked_q   <= 1'b0;
    end else begin
      if (do_ctrl) begin
        ctrl_inten <= i_pwdata[0];
        ctrl_resen <= i_pwdata[1];
      end
      if (do_load) load_q <= load_next;
      if (do_lock) locked_q <= (i_pwdata != LOCK_KEY);
    end
  end

  // Software reloads take priority over an expiry landing on the same edge.
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      value_q     <= LOAD_RST;
      ris_q       <= 1'b0;
      wdt_reset_q <= 1'b0;
    end else if (do_intclr) begin
      value_q <= load_q;
      ris_q   <= 1'b0;
    end else if (do_load) begin
      value_q <= load_next;
    end else if (ctrl_inten) begin
      if (value_q != 32'd0) begin
        value_q <= value_q - 32'd1;
      end else begin
        value_q <= load_q;
        if (!ris_q)          ris_q       <= 1'b1;
        else if (ctrl_resen) wdt_reset_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_wdt.sv
// Directed testbench for apb_wdt: register map, countdown, reset request, lock and protocol errors.
module tb_apb_wdt;

  localparam logic [11:0] A_CTRL = 12'h000, A_LOAD = 12'h004, A_VALUE = 12'h008,
                          A_INTCLR = 12'h00C, A_RIS = 12'h010, A_MIS = 12'h014,
                          A_LOCK = 12'h018, A_BAD = 12'h020;
  localparam logic [31:0] KEY = 32'h1ACC_E551;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [2:0]  pprot = 3'b001;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata;
  logic        pready, pslverr, irq, wdt_rst;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_wdt dut (
    .i_pclk(clk), .i_preset(rst), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pprot(pprot), .i_pstrb(pstrb),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_irq_wdt(irq), .o_wdt_reset(wdt_rst)
  );

  task automatic apply_reset();
    @(negedge clk);
    psel = 0; penable = 0; pwrite = 0; pprot = 3'b001; pstrb = 4'hF;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Returns on the falling edge right after the commit edge.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic e);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(negedge clk);
    penable = 1;
    #1 e = pslverr;
    @(negedge clk);
    psel = 0; penable = 0; pwrite = 0; pstrb = 4'hF; pprot = 3'b001;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk);
    penable = 1;
    #1 begin d = prdata; e = pslverr; end
    @(negedge clk);
    psel = 0; penable = 0;
  endtask

  // Zero-edge read inside the low half-cycle, for cycle-exact observation.
  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    psel = 1; penable = 1; pwrite = 0; paddr = a;
    #1 d = prdata;
    #1 begin psel = 0; penable = 0; end
  endtask

  task automatic test_reset();
    logic [11:0] addrs [7] = '{A_CTRL, A_LOAD, A_VALUE, A_INTCLR, A_RIS, A_MIS, A_LOCK};
    logic [31:0] exps  [7] = '{32'h0, 32'hFFFF, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] d;
    logic e;
    apply_reset();
    n_cmp++; if (pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready got %b want 1", pready); end
    n_cmp++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_cmp++; if (wdt_rst !== 1'b0) begin n_fail++; $display("FAIL reset_wdt_reset got %b want 0", wdt_rst); end
    for (int i = 0; i < 7; i++) begin
      apb_read(addrs[i], d, e);
      n_cmp++;
      if (d !== exps[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read[%h] got %h err %b want %h err 0", addrs[i], d, e, exps[i]);
      end
    end
  endtask

  task automatic test_countdown();
    logic [31:0] exps [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    logic [31:0] d, r;
    logic e;
    apply_reset();
    apb_write(A_LOAD, 32'd3, 4'hF, 3'b001, e);
    apb_write(A_CTRL, 32'd1, 4'hF, 3'b001, e);
    for (int i = 0; i < 5; i++) begin
      peek(A_VALUE, d);
      n_cmp++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL countdown_value[%0d] got %0d want %0d", i, d, exps[i]); end
      peek(A_RIS, r);
      n_cmp++;
      if (r[0] !== (i == 4) || irq !== (i == 4)) begin
        n_fail++; $display("FAIL countdown_ris[%0d] got ris %b irq %b want %b", i, r[0], irq, (i == 4));
      end
      if (i == 4) begin
        peek(A_MIS, r);
        n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL countdown_mis got %h want 1", r); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_request();
    logic [31:0] r;
    logic e;
    apply_reset();
    apb_write(A_LOAD, 32'd3, 4'hF, 3'b001, e);
    apb_write(A_CTRL, 32'd3, 4'hF, 3'b001, e);
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if (wdt_rst !== (i >= 8)) begin n_fail++; $display("FAIL resreq_cycle[%0d] got %b want %b", i, wdt_rst, (i >= 8)); end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (wdt_rst !== 1'b1) begin n_fail++; $display("FAIL resreq_sticky got %b want 1", wdt_rst); end
    apb_write(A_INTCLR, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (wdt_rst !== 1'b1) begin n_fail++; $display("FAIL resreq_after_intclr got %b want 1", wdt_rst); end
    apply_reset();
    n_cmp++; if (wdt_rst !== 1'b0) begin n_fail++; $display("FAIL resreq_cleared got %b want 0", wdt_rst); end

    apb_write(A_LOAD, 32'd3, 4'hF, 3'b001, e);
    apb_write(A_CTRL, 32'd3, 4'hF, 3'b001, e);
    repeat (4) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL serviced_irq got %b want 1", irq); end
    apb_write(A_INTCLR, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL serviced_irq_cleared got %b want 0", irq); end
    for (int i = 7; i <= 14; i++) begin
      n_cmp++;
      if (wdt_rst !== 1'b0) begin n_fail++; $display("FAIL serviced_wdt_reset[%0d] got %b want 0", i, wdt_rst); end
      if (i == 11) begin
        peek(A_RIS, r);
        n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL serviced_ris_again got %h want 1", r); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [31:0] d;
    logic e;
    apply_reset();
    apb_write(A_CTRL, 32'd1, 4'hF, 3'b001, e);
    apb_write(A_LOCK, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL lock_write_err got %b want 0", e); end
    apb_read(A_LOCK, d, e);
    n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL lock_status got %h want 1", d); end
    apb_write(A_CTRL, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL locked_ctrl_err got %b want 1", e); end
    apb_read(A_CTRL, d, e);
    n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL locked_ctrl_value got %h want 1", d); end
    apb_write(A_LOAD, 32'd5, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL locked_load_err got %b want 1", e); end
    apb_write(A_INTCLR, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL locked_intclr_err got %b want 1", e); end
    apb_write(A_LOCK, KEY, 4'hF, 3'b001, e);
    apb_read(A_LOCK, d, e);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL unlock_status got %h want 0", d); end
    apb_write(A_LOAD, 32'h100, 4'hF, 3'b001, e);
    apb_write(A_CTRL, 32'd0, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL unlocked_ctrl_err got %b want 0", e); end
    repeat (5) @(negedge clk);
    peek(A_VALUE, d);
    n_cmp++; if (d !== 32'hFD) begin n_fail++; $display("FAIL stopped_value got %h want 000000fd", d); end
  endtask

  task automatic test_protocol();
    logic [31:0] d;
    logic e;
    apply_reset();
    apb_read(A_BAD, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got %h err %b want 0 err 1", d, e); end
    apb_write(A_LOAD, 32'h1234, 4'hF, 3'b000, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL unpriv_write_err got %b want 1", e); end
    apb_read(A_LOAD, d, e);
    n_cmp++; if (d !== 32'hFFFF) begin n_fail++; $display("FAIL unpriv_load_value got %h want 0000ffff", d); end
    apb_write(A_VALUE, 32'd7, 4'hF, 3'b001, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL ro_write_err got %b want 1", e); end
    apb_write(A_LOAD, 32'd0, 4'hF, 3'b001, e);
    apb_write(A_LOAD, 32'hAABBCCDD, 4'b0101, 3'b001, e);
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL strb_load_err got %b want 0", e); end
    apb_read(A_LOAD, d, e);
    n_cmp++; if (d !== 32'h00BB00DD) begin n_fail++; $display("FAIL strb_load_value got %h want 00bb00dd", d); end
    apb_read(A_VALUE, d, e);
    n_cmp++; if (d !== 32'h00BB00DD) begin n_fail++; $display("FAIL strb_value_follow got %h want 00bb00dd", d); end
    apb_write(A_CTRL, 32'd1, 4'b1110, 3'b001, e);
    apb_read(A_CTRL, d, e);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_lane0_only got %h want 0", d); end
  endtask

  task automatic test_intclr_at_expiry();
    logic [31:0] d;
    logic e;
    apply_reset();
    apb_write(A_LOAD, 32'd3, 4'hF, 3'b001, e);
    apb_write(A_CTRL, 32'd1, 4'hF, 3'b001, e);
    @(negedge clk);
    apb_write(A_INTCLR, 32'd0, 4'hF, 3'b001, e);
    peek(A_RIS, d);
    n_cmp++; if (d !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL intclr_expiry_ris got %h irq %b want 0 irq 0", d, irq); end
    peek(A_VALUE, d);
    n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL intclr_expiry_value got %0d want 3", d); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    logic e;
    apply_reset();
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = A_CTRL; pwdata = 32'd3;
    @(negedge clk);
    penable = 1;
    #1 rst = 1;
    @(posedge clk);
    #1 begin psel = 0; penable = 0; pwrite = 0; end
    @(negedge clk);
    rst = 0;
    apb_read(A_CTRL, d, e);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL mid_transfer_reset got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_reset_request();
    test_lock();
    test_protocol();
    test_intclr_at_expiry();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
